// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, default
// latencies and the sign-magnitude divide helper.
package mdu_pkg;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
    } div_res_t;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    function automatic div_res_t mdu_divide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        div_res_t    res;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        // A zero divisor result is discarded by the caller; avoid an X source.
        if (mag_b == 32'd0) mag_b = 32'd1;
        q = mag_a / mag_b;
        r = mag_a % mag_b;
        res.quo = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
        res.rem = neg_a ? (~r + 32'd1) : r;
        return res;
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Fixed-latency mult/div driven by
// a down-counter; mthi/mtlo complete in a single cycle without going busy.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               issue;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    div_res_t           div_res;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_valid;

    assign issue = start & (op[2] == 1'b0);

    // Results are computed only from the operands latched at issue.
    assign prod_s  = signed'({{32{a_q[31]}}, a_q}) * signed'({{32{b_q[31]}}, b_q});
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign div_res = mdu_divide(a_q, b_q, op_q == MDU_DIV);

    always_comb begin
        res_hi    = hi_q;
        res_lo    = lo_q;
        res_valid = 1'b1;
        case (op_q)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            default: begin
                res_hi    = div_res.rem;
                res_lo    = div_res.quo;
                res_valid = (b_q != 32'd0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_BUSY;
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = (op[1] == 1'b0) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (start && op == MDU_MTHI) begin
                    hi_d = A;
                end else if (start && op == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (res_valid) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_BUSY);
        stall_req = busy | issue;
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner
// sequences and randomized ops against a plain-arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the MIPS definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                h = p[63:32]; l = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32]; l = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b != 32'd0) begin
                    sa = (o == 3'd2) ? longint'($signed(a)) : longint'({32'd0, a});
                    sb = (o == 3'd2) ? longint'($signed(b)) : longint'({32'd0, b});
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge busy is low.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int ncyc, input logic [31:0] eh, input logic [31:0] el,
                         input string name);
        int n;
        start = 1'b1; op = o; A = a; B = b;
        #1 chk({name, " stall_issue"}, 64'(stall_req), 64'd1);
        @(posedge clk);
        #1 start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall_req !== 1'b1) chk({name, " stall_busy"}, 64'(stall_req), 64'd1);
            @(negedge clk);
        end
        chk({name, " busy_len"}, 64'(n), 64'(ncyc));
        chk({name, " hi"}, 64'(hi), 64'(eh));
        chk({name, " lo"}, 64'(lo), 64'(el));
        m_hi = eh; m_lo = el;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input string name);
        start = 1'b1; op = o; A = a;
        #1 chk({name, " stall"}, 64'(stall_req), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        model(o, a, 32'd0, m_hi, m_lo);
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " hi"}, 64'(hi), 64'(m_hi));
        chk({name, " lo"}, 64'(lo), 64'(m_lo));
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [2:0]  ro;
        logic [31:0] ra, rb, eh, el;

        tbl[0] = '{3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult_neg1x2"};
        tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5, "multu_maxx2"};
        tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2"};
        tbl[3] = '{3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 10, "divu_7_2"};
        tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, "div_ovf"};
        tbl[5] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5, "mult_maxpos"};
        tbl[6] = '{3'd2, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10, "div_7_m2"};

        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        #22;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset stall", 64'(stall_req), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cyc, tbl[i].hi, tbl[i].lo, tbl[i].name);

        // Divide by zero keeps the preloaded HI/LO.
        do_mt(3'd4, 32'h11, "mthi");
        do_mt(3'd5, 32'h22, "mtlo");
        do_op(3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22, "div_by0");
        do_op(3'd3, 32'd9, 32'd0, 10, 32'h11, 32'h22, "divu_by0");

        // Reserved ops do nothing.
        for (int k = 6; k < 8; k++) begin
            start = 1'b1; op = 3'(k); A = 32'h55;
            #1 chk("resv stall", 64'(stall_req), 64'd0);
            @(posedge clk);
            #1 start = 1'b0;
            chk("resv busy", 64'(busy), 64'd0);
            chk("resv hilo", {hi, lo}, {32'h11, 32'h22});
            @(negedge clk);
        end

        // Requests while busy are ignored.
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            start = (n == 2 || n == 3);
            op    = (n == 2) ? 3'd2 : 3'd4;
            A     = (n == 2) ? 32'd100 : 32'hDEAD;
            B     = 32'd7;
            #1 chk("ign stall", 64'(stall_req), 64'd1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign busy_len", 64'(n), 64'd5);
        chk("ign hilo", {hi, lo}, {32'd0, 32'd15});
        @(negedge clk);
        chk("ign still_idle", 64'(busy), 64'd0);
        m_hi = 32'd0; m_lo = 32'd15;

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 4) begin
            n++;
            if (n < 4) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid hi", 64'(hi), 64'd0);
        chk("rst_mid lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        do_op(3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, "multu_after_rst");

        // Back-to-back: second op issued in the single idle cycle after busy falls.
        do_op(3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, "b2b multu");
        do_op(3'd3, 32'd43, 32'd5, 10, 32'd3, 32'd8, "b2b divu");

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'($urandom_range(0, 100))};
            if (ro >= 3'd4) begin
                do_mt(ro, ra, "rand_mt");
            end else begin
                eh = m_hi; el = m_lo;
                model(ro, ra, rb, eh, el);
                do_op(ro, ra, rb, (ro[1] == 1'b0) ? 5 : 10, eh, el, "rand_op");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
